sync_fifo_param: RTL

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and registered read data. Used where producer and consumer share one clock domain, next to the dual-clock FIFOs in the same datapath, so no pointer synchronisers are needed. Width, depth and thresholds are set per instance. Optional overflow/underflow error flags are compiled in by macro.

---
 rtl/sync_fifo_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, flush and registered read data.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky wovf/runf error flags; otherwise they read as 0.
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   count,
    output logic             wovf,
    output logic             runf
);

    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE + 1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE + 1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             wacc, racc;

    // Flags come from the count register alone, so they never depend on this cycle's requests.
    assign wfull  = (count_q == DEPTH_C);
    assign rempty = (count_q == '0);
    assign afull  = (count_q >= AFULL_C);
    assign aempty = (count_q <= AEMPTY_C);
    assign count  = count_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

    assign wacc = winc & ~wfull & ~flush;
    assign racc = rinc & ~rempty & ~flush;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wacc) wptr_d = wptr_q + 1'b1;
            if (racc) begin
                rptr_d   = rptr_q + 1'b1;
                rdata_d  = mem_q[rptr_q];
                rvalid_d = 1'b1;
            end
            case ({wacc, racc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable because count/pointers are reset.
    always_ff @(posedge clk) begin
        if (wacc) mem_q[wptr_q] <= wdata;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic wovf_q, wovf_d;
    logic runf_q, runf_d;

    always_comb begin
        wovf_d = wovf_q;
        runf_d = runf_q;
        if (flush) begin
            wovf_d = 1'b0;
            runf_d = 1'b0;
        end else begin
            if (winc && wfull)  wovf_d = 1'b1;
            if (rinc && rempty) runf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wovf_q <= 1'b0;
            runf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
            runf_q <= runf_d;
        end
    end

    assign wovf = wovf_q;
    assign runf = runf_q;
`else
    assign wovf = 1'b0;
    assign runf = 1'b0;
`endif

endmodule
